// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU port m0, loader port m1),
// the data-memory arbiter and the single-port data memory.
//
// Handshake: a master holds mX_req (with we/addr/wdata/lock) stable while
// it waits; the access is accepted and completes on the rising edge where
// mX_req && mX_gnt. A read result appears on mX_rdata with a one-cycle
// mX_rvalid pulse in the cycle after that edge. There is no back-pressure
// on read data.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7
);
    // CPU load/store port
    logic              m0_req;
    logic              m0_we;
    logic [31:0]       m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [31:0]       m0_rdata;
    logic              m0_stall;

    // Debug / program-loader port
    logic              m1_req;
    logic              m1_we;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [31:0]       m1_rdata;

    // Single-port data memory
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_stall,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Requester and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_stall,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory. Round-robin between
// the CPU (m0) and the loader (m1); the loader may hold the memory for a
// burst with m1_lock, but never for more than MAX_HOLD consecutive extra
// grants while the CPU is waiting. Grants are combinational so an access
// completes in the same cycle it is requested when uncontended.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int MAX_HOLD = 4   // 1..255
) (
    input  logic                clk,
    input  logic                rstn,
    dmem_arbiter_if.slave       bus,
    output logic [1:0]          dbg_state_o,
    output logic [7:0]          dbg_hold_o,
    output logic                dbg_last_o
);

    // State = owner of the previous cycle's grant (IDLE if none).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_e      state_q, state_d;
    logic        last_q, last_d;       // master of the most recent grant
    logic [7:0]  hold_q, hold_d;       // consecutive grants while other waits
    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        win_valid;            // somebody is granted this cycle
    logic        win_m1;               // winner is m1 (valid with win_valid)
    logic        gnt0, gnt1;
    logic        same_owner;
    logic        other_req;

    // Address bits outside the word index are intentionally ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.m0_addr[31:ADDR_W+2], bus.m0_addr[1:0],
                                bus.m1_addr[31:ADDR_W+2], bus.m1_addr[1:0]};

    // Pick the winner: single requester wins outright; on a tie the locked
    // loader keeps the memory until the hold limit, otherwise alternate.
    always_comb begin
        win_valid = 1'b0;
        win_m1    = 1'b0;
        if (!rstn) begin
            win_valid = 1'b0;
        end else if (bus.m0_req && bus.m1_req) begin
            win_valid = 1'b1;
            if (state_q == OWN1 && bus.m1_lock && hold_q < HOLD_MAX) begin
                win_m1 = 1'b1;
            end else begin
                win_m1 = ~last_q;
            end
        end else if (bus.m0_req) begin
            win_valid = 1'b1;
        end else if (bus.m1_req) begin
            win_valid = 1'b1;
            win_m1    = 1'b1;
        end
    end

    assign gnt0 = win_valid & ~win_m1;
    assign gnt1 = win_valid &  win_m1;

    assign bus.m0_gnt   = gnt0;
    assign bus.m1_gnt   = gnt1;
    assign bus.m0_stall = bus.m0_req & ~gnt0;

    // Route the winner's access to the memory; drive zeros when idle.
    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (gnt1) begin
            bus.mem_we   = bus.m1_we;
            bus.mem_addr = bus.m1_addr[ADDR_W+1:2];
            bus.mem_din  = bus.m1_we ? bus.m1_wdata : 32'h0;
        end else if (gnt0) begin
            bus.mem_we   = bus.m0_we;
            bus.mem_addr = bus.m0_addr[ADDR_W+1:2];
            bus.mem_din  = bus.m0_we ? bus.m0_wdata : 32'h0;
        end
    end

    // Next owner, round-robin pointer and hold counter.
    always_comb begin
        same_owner = (state_q == OWN0 && gnt0) || (state_q == OWN1 && gnt1);
        other_req  = win_m1 ? bus.m0_req : bus.m1_req;

        state_d = IDLE;
        last_d  = last_q;
        hold_d  = 8'd0;
        if (win_valid) begin
            state_d = win_m1 ? OWN1 : OWN0;
            last_d  = win_m1;
            if (same_owner && other_req) begin
                hold_d = (hold_q < HOLD_MAX) ? hold_q + 8'd1 : HOLD_MAX;
            end
        end
    end

    // Owner FSM plus registered read-return path for both masters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= gnt0 & ~bus.m0_we;
            rvalid1_q <= gnt1 & ~bus.m1_we;
            if (gnt0 && !bus.m0_we) begin
                rdata0_q <= bus.mem_dout;
            end
            if (gnt1 && !bus.m1_we) begin
                rdata1_q <= bus.mem_dout;
            end
        end
    end

    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m1_rdata  = rdata1_q;

    assign dbg_state_o = state_q;
    assign dbg_hold_o  = hold_q;
    assign dbg_last_o  = last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of per-cycle vectors with
// hand-computed expectations, then hand-written sequences for the locked
// burst, memory readback and reset-discard cases. A behavioural
// single-port memory sits on the bus.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam logic B0 = 1'b0;
  localparam logic B1 = 1'b1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic clk;
  logic rstn;
  logic preload;
  logic [1:0] dbg_state;
  logic [7:0] dbg_hold;
  logic dbg_last;
  logic [31:0] dm [0:127];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state),
    .dbg_hold_o  (dbg_hold),
    .dbg_last_o  (dbg_last)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = dm[bus.mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) dm[i] <= 32'hA000_0000 | i;
      dm[4] <= 32'hCAFE_F00D;
    end else if (bus.mem_we) begin
      dm[bus.mem_addr] <= bus.mem_din;
    end
  end

  typedef struct {
    logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic lk;
    logic g0; logic g1; logic st0; logic mwe; logic [6:0] maddr; logic [31:0] mdin;
    logic rv0; logic [31:0] rd0; logic rv1; logic [31:0] rd1;
    logic [1:0] st; logic [7:0] hold;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.m0_req = v.r0; bus.m0_we = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.r1; bus.m1_we = v.w1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
    bus.m1_lock = v.lk;
  endtask

  // Drive at the falling edge, compare 2 ns later, well before the rising edge.
  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    check({tag, " m0_gnt"},    {31'h0, bus.m0_gnt},    {31'h0, v.g0});
    check({tag, " m1_gnt"},    {31'h0, bus.m1_gnt},    {31'h0, v.g1});
    check({tag, " m0_stall"},  {31'h0, bus.m0_stall},  {31'h0, v.st0});
    check({tag, " mem_we"},    {31'h0, bus.mem_we},    {31'h0, v.mwe});
    check({tag, " mem_addr"},  {25'h0, bus.mem_addr},  {25'h0, v.maddr});
    check({tag, " mem_din"},   bus.mem_din,            v.mdin);
    check({tag, " m0_rvalid"}, {31'h0, bus.m0_rvalid}, {31'h0, v.rv0});
    check({tag, " m0_rdata"},  bus.m0_rdata,           v.rd0);
    check({tag, " m1_rvalid"}, {31'h0, bus.m1_rvalid}, {31'h0, v.rv1});
    check({tag, " m1_rdata"},  bus.m1_rdata,           v.rd1);
    check({tag, " state"},     {30'h0, dbg_state},     {30'h0, v.st});
    check({tag, " hold"},      {24'h0, dbg_hold},      {24'h0, v.hold});
  endtask

  initial begin
    vec_t v;
    logic exp_g1 [12];
    logic [7:0] exp_hold [12];
    logic [1:0] exp_st [12];

    // fields: r0 w0 a0 d0 | r1 w1 a1 d1 lk | g0 g1 st0 mwe maddr mdin | rv0 rd0 rv1 rd1 | state hold
    vecs[0]  = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B0,32'h0,B0,32'h0, S_IDLE,8'd0};
    vecs[1]  = '{B1,B0,32'h04,32'h0, B1,B0,32'h08,32'h0,B0, B1,B0,B0,B0,7'd1,32'h0, B0,32'h0,B0,32'h0, S_IDLE,8'd0};
    vecs[2]  = '{B1,B0,32'h04,32'h0, B1,B0,32'h08,32'h0,B0, B0,B1,B1,B0,7'd2,32'h0, B1,32'hA0000001,B0,32'h0, S_OWN0,8'd0};
    vecs[3]  = '{B1,B0,32'h04,32'h0, B1,B0,32'h08,32'h0,B0, B1,B0,B0,B0,7'd1,32'h0, B0,32'hA0000001,B1,32'hA0000002, S_OWN1,8'd0};
    vecs[4]  = '{B1,B0,32'h04,32'h0, B1,B0,32'h08,32'h0,B0, B0,B1,B1,B0,7'd2,32'h0, B1,32'hA0000001,B0,32'hA0000002, S_OWN0,8'd0};
    vecs[5]  = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B0,32'hA0000001,B1,32'hA0000002, S_OWN1,8'd0};
    vecs[6]  = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B0,32'hA0000001,B0,32'hA0000002, S_IDLE,8'd0};
    vecs[7]  = '{B1,B0,32'h10,32'h0, B0,B0,32'h0,32'h0,B0, B1,B0,B0,B0,7'd4,32'h0, B0,32'hA0000001,B0,32'hA0000002, S_IDLE,8'd0};
    vecs[8]  = '{B1,B0,32'hFFFFFE13,32'h0, B0,B0,32'h0,32'h0,B0, B1,B0,B0,B0,7'd4,32'h0, B1,32'hCAFEF00D,B0,32'hA0000002, S_OWN0,8'd0};
    vecs[9]  = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B1,32'hCAFEF00D,B0,32'hA0000002, S_OWN0,8'd0};
    vecs[10] = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B0,32'hCAFEF00D,B0,32'hA0000002, S_IDLE,8'd0};
    vecs[11] = '{B0,B0,32'h0,32'h0, B1,B1,32'h20,32'h12345678,B0, B0,B1,B0,B1,7'd8,32'h12345678, B0,32'hCAFEF00D,B0,32'hA0000002, S_IDLE,8'd0};
    vecs[12] = '{B1,B0,32'h20,32'h0, B0,B0,32'h0,32'h0,B0, B1,B0,B0,B0,7'd8,32'h0, B0,32'hCAFEF00D,B0,32'hA0000002, S_OWN1,8'd0};
    vecs[13] = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B1,32'h12345678,B0,32'hA0000002, S_OWN0,8'd0};
    vecs[14] = '{B1,B1,32'h30,32'h11111111, B1,B1,32'h34,32'h22222222,B0, B0,B1,B1,B1,7'd13,32'h22222222, B0,32'h12345678,B0,32'hA0000002, S_IDLE,8'd0};
    vecs[15] = '{B1,B1,32'h30,32'h11111111, B1,B1,32'h34,32'h22222222,B0, B1,B0,B0,B1,7'd12,32'h11111111, B0,32'h12345678,B0,32'hA0000002, S_OWN1,8'd0};
    vecs[16] = '{B0,B0,32'h0,32'h0, B1,B0,32'h34,32'h0,B1, B0,B1,B0,B0,7'd13,32'h0, B0,32'h12345678,B0,32'hA0000002, S_OWN0,8'd0};
    vecs[17] = '{B1,B0,32'h30,32'h0, B0,B0,32'h0,32'h0,B0, B1,B0,B0,B0,7'd12,32'h0, B0,32'h12345678,B1,32'h22222222, S_OWN1,8'd0};
    vecs[18] = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B1,32'h11111111,B0,32'h22222222, S_OWN0,8'd0};
    vecs[19] = '{B0,B0,32'h0,32'h0, B0,B0,32'h0,32'h0,B0, B0,B0,B0,B0,7'd0,32'h0, B0,32'h11111111,B0,32'h22222222, S_IDLE,8'd0};

    exp_g1   = '{B1,B1,B1,B1,B1,B0,B1,B1,B1,B1,B1,B0};
    exp_hold = '{8'd0,8'd0,8'd1,8'd2,8'd3,8'd4,8'd0,8'd0,8'd1,8'd2,8'd3,8'd4};
    exp_st   = '{S_IDLE,S_OWN1,S_OWN1,S_OWN1,S_OWN1,S_OWN1,S_OWN0,S_OWN1,S_OWN1,S_OWN1,S_OWN1,S_OWN1};

    // reset block
    rstn = 1'b0;
    preload = 1'b1;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rstn = 1'b1;
    #2;
    check("reset last", {31'h0, dbg_last}, 32'h1);

    // table: round-robin ties, single reads, aliasing, write-then-read
    for (int i = 0; i < 20; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // locked burst: m1 alone first, then both; m1 gets 1+MAX_HOLD grants
    for (int k = 0; k < 12; k++) begin
      v = vecs[0];
      v.r0 = (k != 0); v.a0 = 32'h40;
      v.r1 = B1; v.w1 = B1; v.a1 = (k * 4) & 32'h1C; v.d1 = 32'hB000_0000 + k; v.lk = B1;
      v.g1 = exp_g1[k];
      v.g0 = (k != 0) && !exp_g1[k];
      v.st0 = (k != 0) && exp_g1[k];
      v.mwe = exp_g1[k];
      v.maddr = exp_g1[k] ? 7'((k * 4) & 28) >> 2 : 7'd16;
      v.mdin = exp_g1[k] ? 32'hB000_0000 + k : 32'h0;
      v.rv0 = (k == 6);
      v.rd0 = (k >= 6) ? 32'hA000_0010 : 32'h1111_1111;
      v.rv1 = B0; v.rd1 = 32'h2222_2222;
      v.st = exp_st[k]; v.hold = exp_hold[k];
      apply_vec($sformatf("lock%0d", k), v);
    end

    // readback of words written during the burst
    v = vecs[0]; v.rv0 = B1; v.rd0 = 32'hA000_0010; v.rd1 = 32'h2222_2222; v.st = S_OWN0;
    apply_vec("lock_done", v);
    v = vecs[0]; v.r0 = B1; v.a0 = 32'h1C; v.g0 = B1; v.maddr = 7'd7;
    v.rd0 = 32'hA000_0010; v.rd1 = 32'h2222_2222; v.st = S_IDLE;
    apply_vec("rb_1c", v);
    v = vecs[0]; v.r0 = B1; v.a0 = 32'h00; v.g0 = B1; v.maddr = 7'd0;
    v.rv0 = B1; v.rd0 = 32'hB000_0007; v.rd1 = 32'h2222_2222; v.st = S_OWN0;
    apply_vec("rb_00", v);
    v = vecs[0]; v.rv0 = B1; v.rd0 = 32'hB000_0008; v.rd1 = 32'h2222_2222; v.st = S_OWN0;
    apply_vec("rb_end", v);

    // reset arriving on the edge that completes a granted read
    @(negedge clk);
    v = vecs[0]; v.r0 = B1; v.a0 = 32'h10;
    drive(v);
    #2;
    check("rst gnt before", {31'h0, bus.m0_gnt}, 32'h1);
    #1 rstn = 1'b0;
    @(posedge clk);
    #2;
    check("rst m0_rvalid", {31'h0, bus.m0_rvalid}, 32'h0);
    check("rst m0_rdata", bus.m0_rdata, 32'h0);
    check("rst m1_rdata", bus.m1_rdata, 32'h0);
    check("rst gnt low", {31'h0, bus.m0_gnt}, 32'h0);
    check("rst mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(vecs[0]);
    #2;
    check("post rst rvalid", {31'h0, bus.m0_rvalid}, 32'h0);
    check("post rst last", {31'h0, dbg_last}, 32'h1);
    check("post rst hold", {24'h0, dbg_hold}, 32'h0);
    @(negedge clk);
    #2;
    check("post rst rvalid2", {31'h0, bus.m0_rvalid}, 32'h0);
    check("post rst mem_addr", {25'h0, bus.mem_addr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
